lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store initiator that drives the single-port on-chip word memory on behalf of the core. It accepts one byte, halfword or word request at a time over a valid/ready handshake, converts byte addresses to word addresses, and performs lane extraction with sign/zero extension for loads. Sub-word stores use read-modify-write, because the memory port has no byte enables. It sits between the core's execute stage and the `memory` instance.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words in the attached memory.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  loads only; zero-extend instead of sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, low-aligned.
- `resp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  request rejected, with no memory access.
- `mem_addr`  out  32  word address, `{2'b00, addr[31:2]}`.
- `mem_write_enable`  out  1  write strobe.
- `mem_write_data`  out  32  write word.
- `mem_read_data`  in  32  valid one cycle after `mem_addr` is presented.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, RMW_ADDR, RMW_DATA, RMW_WR.
- `req_ready` = (state == IDLE). `req_valid` while busy is ignored; the requester holds the request.
- Accept path: address, size, write, unsigned and wdata are captured, then:
  - Load: IDLE→RD_ADDR→RD_DATA→IDLE.
  - Word store: IDLE→WR→IDLE.
  - Byte/half store: IDLE→RMW_ADDR→RMW_DATA→RMW_WR→IDLE.
- Errors stay in IDLE and pulse `resp_valid` with `resp_err`=1 the next cycle. Error cases:
  - Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - `req_size`=11.
- Lanes are little-endian.
  - Byte k = addr[1:0] uses bits [8k+7:8k].
  - Half h = addr[1] uses bits [16h+15:16h].
- Loads: the selected lane is sign-extended from its top bit unless `req_unsigned`.
- RMW_DATA: `mem_read_data` is merged with the low byte/half of the captured wdata into a register. RMW_WR writes that register.
- `mem_write_enable` = 1 only in WR and RMW_WR. `mem_addr` = captured word address in every non-IDLE state.
- In IDLE, `mem_write_data` = 0. In WR it is the full wdata; in RMW_WR it is the merged word.
- `resp_*` are registered. `resp_rdata` is latched at the end of RD_DATA.
- There is no response backpressure; the consumer must take the `resp_valid` pulse.
- Reset values: state IDLE, `req_ready`=1, all other outputs 0.
- Reset mid-operation aborts immediately. `mem_write_enable` drops asynchronously, no write is issued unless the write edge already occurred, and no response is produced.

## Timing
- Request accepted in cycle T.
- Load:
  - RD_ADDR in T+1, memory samples `mem_addr`.
  - RD_DATA in T+2.
  - `resp_valid` in T+3.
- Word store: write in T+1, `resp_valid` in T+2.
- Sub-word store:
  - Read address in T+1, merge in T+2.
  - Write in T+3, `resp_valid` in T+4.
- Error: `resp_valid`/`resp_err` in T+1.
- `req_ready` is high in the `resp_valid` cycle, so back-to-back requests are accepted without a bubble.

## Configuration
- `LSU_RANGE_CHECK_EN` defined:
  - word address ≥ `MEM_WORDS` is flagged `resp_err`;
  - no memory cycle is run;
  - timing matches misalignment errors.
- `LSU_RANGE_CHECK_EN` undefined: there is no check, and the address is passed through for the memory to alias.

## Structure
- `lsu_pkg` holds the `req_size` enum (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the lane-width constants.
- Sub-module `lsu_lane_align` is combinational and does two jobs:
  - load extract and extend;
  - store merge, from size, addr[1:0], unsigned, old word and wdata.
- The FSM and registers live in `lsu_mem_port`.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 → `mem_addr`=4 with `mem_write_enable` for one cycle at T+1; load returns 0xDEADBEEF at T+3.
- Preload word 4 = 0x80FF7F01, then load:
  - LB 0x13 → 0xFFFFFF80;
  - LBU 0x13 → 0x00000080;
  - LH 0x12 → 0xFFFF80FF;
  - LHU 0x10 → 0x00007F01.
- Preload 0x11223344, then SB 0xAA at 0x11 → one read cycle then one write of 0x1122AA44; `resp_valid` at T+4.
- LW 0x02 or size=11 → `resp_err`=1 at T+1, `resp_rdata`=0, no write strobe.
- Assert reset during RMW_DATA → `mem_write_enable` never rises, memory unchanged, `req_ready`=1 after release.
- LW 0x400 with `MEM_WORDS`=256 → with `LSU_RANGE_CHECK_EN`, `resp_err` at T+1; without it, `mem_addr`=0x100 and the load completes.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory port: request sizes, FSM states and lane widths.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ADDR  = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR       = 3'd3,
        ST_RMW_ADDR = 3'd4,
        ST_RMW_DATA = 3'd5,
        ST_RMW_WR   = 3'd6
    } lsu_state_e;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extract/extend and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged_word
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;
    logic [4:0]        byte_lsb;
    logic [4:0]        half_lsb;

    assign byte_lsb  = {addr_lo, 3'b000};
    assign half_lsb  = {addr_lo[1], 4'b0000};
    assign byte_lane = old_word[byte_lsb +: BYTE_W];
    assign half_lane = old_word[half_lsb +: HALF_W];

    always_comb begin
        load_data   = old_word;
        merged_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = is_unsigned ? {{(WORD_W-BYTE_W){1'b0}}, byte_lane}
                                        : {{(WORD_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
                merged_word = old_word;
                merged_word[byte_lsb +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {{(WORD_W-HALF_W){1'b0}}, half_lane}
                                        : {{(WORD_W-HALF_W){half_lane[HALF_W-1]}}, half_lane};
                merged_word = old_word;
                merged_word[half_lsb +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: begin
                load_data   = old_word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for the single-port word memory; sub-word stores use read-modify-write.
// Optional LSU_RANGE_CHECK_EN rejects word addresses at or beyond MEM_WORDS.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [31:0] req_word_addr;
    logic [31:0] word_addr_q;
    logic        misaligned;
    logic        bad_size;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_word_addr = {2'b00, req_addr[31:2]};
    assign word_addr_q   = {2'b00, addr_q[31:2]};

    assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign bad_size     = (req_size == 2'b11);
    assign out_of_range = RANGE_CHECK && (req_word_addr >= MEM_WORDS);
    assign req_err      = misaligned || bad_size || out_of_range;

    // Both load extract and store merge consume the word the memory returns this cycle.
    lsu_lane_align u_lane_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .old_word    (mem_read_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        size_d           = size_q;
        uns_d            = uns_q;
        wdata_d          = wdata_q;
        merge_d          = merge_q;
        resp_valid_d     = 1'b0;
        resp_err_d       = 1'b0;
        resp_rdata_d     = 32'h0;
        req_ready        = 1'b0;
        mem_addr         = 32'h0;
        mem_write_enable = 1'b0;
        mem_write_data   = 32'h0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        wdata_d = req_wdata;
                        if (!req_write)
                            state_d = ST_RD_ADDR;
                        else if (req_size == SZ_WORD)
                            state_d = ST_WR;
                        else
                            state_d = ST_RMW_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                mem_addr = word_addr_q;
                state_d  = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                mem_addr     = word_addr_q;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                state_d      = ST_IDLE;
            end
            ST_WR: begin
                mem_addr         = word_addr_q;
                mem_write_enable = 1'b1;
                mem_write_data   = wdata_q;
                resp_valid_d     = 1'b1;
                state_d          = ST_IDLE;
            end
            ST_RMW_ADDR: begin
                mem_addr = word_addr_q;
                state_d  = ST_RMW_DATA;
            end
            ST_RMW_DATA: begin
                mem_addr = word_addr_q;
                merge_d  = merged_word;
                state_d  = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_addr         = word_addr_q;
                mem_write_enable = 1'b1;
                mem_write_data   = merge_q;
                resp_valid_d     = 1'b1;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode from state_q, so an async reset drops them without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'h0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: vector table plus reset-abort and back-to-back sequences.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;

    int total;
    int bad;

    lsu_mem_port #(.MEM_WORDS(256)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory model: registered read, aliases on the low 8 word-address bits.
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (mem_write_enable)
            mem[mem_addr[7:0]] <= mem_write_data;
        mem_read_data <= mem[mem_addr[7:0]];
    end

    typedef struct {
        logic        pl;
        logic [7:0]  pl_idx;
        logic [31:0] pl_val;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic [31:0] maddr;
        int          nwr;
        logic [31:0] wr_data;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic pl, input logic [7:0] pi, input logic [31:0] pv,
                                input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int lat, input logic err, input logic [31:0] rd,
                                input logic [31:0] maddr, input int nwr, input logic [31:0] wrd);
        vec_t v;
        v.pl = pl; v.pl_idx = pi; v.pl_val = pv;
        v.w = w; v.sz = sz; v.u = u; v.a = a; v.wd = wd;
        v.lat = lat; v.err = err; v.rd = rd; v.maddr = maddr;
        v.nwr = nwr; v.wr_data = wrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          k;
        int          lat;
        int          nwr;
        logic [31:0] maddr1;
        logic [31:0] last_wr;
        logic        got;
        string       tag;
        tag = $sformatf("v%0d", idx);
        if (v.pl) preload(v.pl_idx, v.pl_val);
        @(negedge clk);
        chk({tag, "_ready_before"}, {31'h0, req_ready}, 32'h1);
        drive_req(v.w, v.sz, v.u, v.a, v.wd);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0; lat = 0; nwr = 0; got = 1'b0; maddr1 = 32'h0; last_wr = 32'h0;
        while (!got && k < 8) begin
            @(negedge clk);
            k++;
            if (k == 1) maddr1 = mem_addr;
            if (mem_write_enable) begin
                nwr++;
                last_wr = mem_write_data;
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = k;
                chk({tag, "_err"},      {31'h0, resp_err}, {31'h0, v.err});
                chk({tag, "_rdata"},    resp_rdata, v.rd);
                chk({tag, "_ready_at_resp"}, {31'h0, req_ready}, 32'h1);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_resp_timeout: got=none expected=resp_valid within 8 cycles", tag);
        end
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_mem_addr"}, maddr1, v.maddr);
        chk({tag, "_write_count"}, nwr, v.nwr);
        if (v.nwr > 0) chk({tag, "_write_data"}, last_wr, v.wr_data);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        int nresp;
        int k;
        logic got;
        total = 0;
        bad   = 0;
        rst = 1'b0;
        pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        //                pl  idx    val           w   sz     u   addr        wdata         lat err rdata         maddr       nwr wr_data
        vecs[0]  = mk(0, 8'd0, 32'h0,         1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 2, 0, 32'h0,        32'h4,   1, 32'hDEADBEEF);
        vecs[1]  = mk(0, 8'd0, 32'h0,         0, 2'b10, 0, 32'h10,  32'h0,        3, 0, 32'hDEADBEEF, 32'h4,   0, 32'h0);
        vecs[2]  = mk(1, 8'd4, 32'h80FF7F01,  0, 2'b00, 0, 32'h13,  32'h0,        3, 0, 32'hFFFFFF80, 32'h4,   0, 32'h0);
        vecs[3]  = mk(0, 8'd0, 32'h0,         0, 2'b00, 1, 32'h13,  32'h0,        3, 0, 32'h00000080, 32'h4,   0, 32'h0);
        vecs[4]  = mk(0, 8'd0, 32'h0,         0, 2'b01, 0, 32'h12,  32'h0,        3, 0, 32'hFFFF80FF, 32'h4,   0, 32'h0);
        vecs[5]  = mk(0, 8'd0, 32'h0,         0, 2'b01, 1, 32'h10,  32'h0,        3, 0, 32'h00007F01, 32'h4,   0, 32'h0);
        vecs[6]  = mk(0, 8'd0, 32'h0,         0, 2'b00, 0, 32'h11,  32'h0,        3, 0, 32'h0000007F, 32'h4,   0, 32'h0);
        vecs[7]  = mk(0, 8'd0, 32'h0,         0, 2'b00, 1, 32'h12,  32'h0,        3, 0, 32'h000000FF, 32'h4,   0, 32'h0);
        vecs[8]  = mk(0, 8'd0, 32'h0,         0, 2'b00, 0, 32'h12,  32'h0,        3, 0, 32'hFFFFFFFF, 32'h4,   0, 32'h0);
        vecs[9]  = mk(1, 8'd4, 32'h11223344,  1, 2'b00, 0, 32'h11,  32'h000000AA, 4, 0, 32'h0,        32'h4,   1, 32'h1122AA44);
        vecs[10] = mk(0, 8'd0, 32'h0,         0, 2'b10, 0, 32'h10,  32'h0,        3, 0, 32'h1122AA44, 32'h4,   0, 32'h0);
        vecs[11] = mk(0, 8'd0, 32'h0,         1, 2'b01, 0, 32'h12,  32'h1234CAFE, 4, 0, 32'h0,        32'h4,   1, 32'hCAFEAA44);
        vecs[12] = mk(0, 8'd0, 32'h0,         1, 2'b00, 0, 32'h13,  32'hFFFFFF77, 4, 0, 32'h0,        32'h4,   1, 32'h77FEAA44);
        vecs[13] = mk(0, 8'd0, 32'h0,         0, 2'b10, 0, 32'h10,  32'h0,        3, 0, 32'h77FEAA44, 32'h4,   0, 32'h0);
        vecs[14] = mk(0, 8'd0, 32'h0,         0, 2'b10, 0, 32'h02,  32'h0,        1, 1, 32'h0,        32'h0,   0, 32'h0);
        vecs[15] = mk(0, 8'd0, 32'h0,         0, 2'b11, 0, 32'h10,  32'h0,        1, 1, 32'h0,        32'h0,   0, 32'h0);
        vecs[16] = mk(0, 8'd0, 32'h0,         0, 2'b01, 0, 32'h11,  32'h0,        1, 1, 32'h0,        32'h0,   0, 32'h0);
        vecs[17] = mk(0, 8'd0, 32'h0,         1, 2'b01, 0, 32'h13,  32'h0000BEEF, 1, 1, 32'h0,        32'h0,   0, 32'h0);
        vecs[18] = mk(0, 8'd0, 32'h0,         1, 2'b10, 0, 32'h12,  32'h12345678, 1, 1, 32'h0,        32'h0,   0, 32'h0);
        vecs[19] = mk(0, 8'd0, 32'h0,         1, 2'b11, 0, 32'h10,  32'h000000EE, 1, 1, 32'h0,        32'h0,   0, 32'h0);
`ifdef LSU_RANGE_CHECK_EN
        vecs[20] = mk(1, 8'd0, 32'hCAFEF00D,  0, 2'b10, 0, 32'h400, 32'h0,        1, 1, 32'h0,        32'h0,   0, 32'h0);
`else
        vecs[20] = mk(1, 8'd0, 32'hCAFEF00D,  0, 2'b10, 0, 32'h400, 32'h0,        3, 0, 32'hCAFEF00D, 32'h100, 0, 32'h0);
`endif
        vecs[21] = mk(1, 8'd5, 32'h80001234,  0, 2'b01, 0, 32'h16,  32'h0,        3, 0, 32'hFFFF8000, 32'h5,   0, 32'h0);
        vecs[22] = mk(0, 8'd0, 32'h0,         1, 2'b00, 0, 32'h14,  32'h000000C3, 4, 0, 32'h0,        32'h5,   1, 32'h800012C3);
        vecs[23] = mk(0, 8'd0, 32'h0,         0, 2'b00, 0, 32'h14,  32'h0,        3, 0, 32'hFFFFFFC3, 32'h5,   0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready",  {31'h0, req_ready}, 32'h1);
        chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset_resp_err",   {31'h0, resp_err}, 32'h0);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_mem_we",     {31'h0, mem_write_enable}, 32'h0);
        chk("reset_mem_addr",   mem_addr, 32'h0);
        chk("reset_mem_wdata",  mem_write_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Reset asserted while the sub-word store sits in RMW_DATA.
        preload(8'd6, 32'h55667788);
        @(negedge clk);
        drive_req(1'b1, 2'b00, 1'b0, 32'h18, 32'h00000011);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_we_now",    {31'h0, mem_write_enable}, 32'h0);
        chk("abort_ready_now", {31'h0, req_ready}, 32'h1);
        nwr = 0;
        nresp = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_write_enable) nwr++;
            if (resp_valid) nresp++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_write_enable) nwr++;
            if (resp_valid) nresp++;
        end
        chk("abort_write_count", nwr, 0);
        chk("abort_resp_count",  nresp, 0);
        chk("abort_mem_intact",  mem[6], 32'h55667788);
        chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
        run_vec(100, mk(0, 8'd0, 32'h0, 0, 2'b10, 0, 32'h18, 32'h0, 3, 0, 32'h55667788, 32'h6, 0, 32'h0));

        // Back-to-back: a load presented in the store's response cycle is taken without a bubble.
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A55A5A);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_store_resp",  {31'h0, resp_valid}, 32'h1);
        chk("b2b_store_ready", {31'h0, req_ready}, 32'h1);
        drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_load_addr", mem_addr, 32'h8);
        got = 1'b0;
        k = 1;
        while (!got && k < 8) begin
            @(negedge clk);
            k++;
            if (resp_valid) got = 1'b1;
        end
        chk("b2b_load_latency", k, 3);
        chk("b2b_load_rdata", resp_rdata, 32'hA5A55A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
